aes_coprocessor_mmio: RTL and testbench
=======================================

// Module: aes_coprocessor_mmio
// PURPOSE
// CPU-mapped AES-128 coprocessor in the 64 KB window 0x0004_xxxx.
// The CPU fills an input buffer with 128-bit blocks and a key, then starts encryption or decryption through a control register.
// A sequencer streams the blocks through an aes128_core submodule into an output buffer.
// The CPU polls the done bit, then reads the results.
// PARAMETERS
// BUF_WORDS   256     32-bit words per buffer (1 KB each); max blocks = BUF_WORDS/4
// TERMINATOR  32'hDEADBEEF  first word of a block that ends processing
// PORTS
// clk_in               in   1   system clock
// rst_in               in   1   asynchronous active-high reset
// cpu_addr_in          in   32  byte address; bits[1:0] ignored (word access)
// cpu_data_in          in   32  write data
// cpu_write_enable_in  in   4   per-byte write strobes; 0 = read
// cpu_data_out         out  32  read data, registered
// BEHAVIOUR
// Interface: one clock, clk_in; reset rst_in is asynchronous, active-high.
// Map (offsets from 0x0004_0000):
//   0x000-0x3FC  input buffer, R/W, byte strobes honoured.
//   0x400        output word 0, RO: number of blocks processed.
//   0x404-0x7FC  output results, RO; CPU writes are ignored.
//   0x800-0x80C  key words 0..3, R/W; key = {k0,k1,k2,k3}, k0 = MSBs; reset 0.
//   0x1000       control: bit0 ENC (W), bit1 DEC (W), bit2 DONE (RO, sticky), bit3 BUSY (RO).
// Addresses outside the window, or unmapped inside it, read 0. Writes there are ignored.
// Read latency: cpu_data_out = contents of the address sampled at the previous clk_in edge (1 cycle). It holds until the next edge.
// Writes take effect at the clk_in edge on which cpu_write_enable_in != 0.
// Start: control write with strobe[0] set and exactly one of ENC/DEC = 1, while not BUSY.
//   Effect: DONE <= 0, BUSY <= 1.
//   Both set, neither set, or written while BUSY: ignored.
// Block b = {in[4b],in[4b+1],in[4b+2],in[4b+3]}, lower-address word = MSBs.
// FSM states:
//   IDLE: wait for start.
//   FETCH: read 4 input words of block b.
//   CHECK: if word in[4b] == TERMINATOR or b == BUF_WORDS/4 -> FINISH; else -> RUN.
//   RUN: 1-cycle start pulse to the core with decrypt_in = DEC; wait for done_out.
//   STORE: write block_out to out[1+4b .. 4+4b]; b++ -> FETCH.
//   FINISH: out[0] <= b; out[1+4b] <= TERMINATOR (if one was found).
//   DONE: set DONE, clear BUSY -> IDLE.
// Core latency is arbitrary. The sequencer waits on done_out with no timeout.
// Key is sampled at each core start.
// CPU writes to the input buffer or key while BUSY are ignored. CPU reads are always served, including mid-run.
// Reset: FSM -> IDLE; DONE=0, BUSY=0; key=0; cpu_data_out=0. Buffer RAM contents are undefined after reset.
// Reset mid-run aborts the run; no DONE is produced.
// Submodule aes128_core ports: clk_in, rst_in, start_in, decrypt_in, key_in[127:0], block_in[127:0], block_out[127:0], done_out.
// done_out is a 1-cycle pulse with block_out valid.
// TESTING
// 1. Write 0x6b2ee973@0x000 and 0x579cac51@0x01D.
//    -> 0x000 reads 6b2ee973 one cycle later; 0x01C reads 579cac51.
// 2. Write 0x00FF@0x004 with we=4'b0001 over 0x11223344.
//    -> reads 112233FF.
// 3. Key 000102..0F; input block 00112233 44556677 8899aabb ccddeeff, then DEADBEEF; write 0x1000=1.
//    -> BUSY, then DONE.
//    -> out 0x400=1, 0x404..0x410 = 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, 0x414=DEADBEEF.
// 4. Load the test-3 ciphertext; write 0x1000=2.
//    -> DONE; 0x404..0x410 = the original plaintext.
// 5. Two blocks + terminator: encrypt then decrypt round-trip.
//    -> 0x400=2; 8 recovered words equal the inputs.
// 6. Write 0x1000=3, then 0x1000=1 while BUSY, then rst_in mid-run.
//    -> the first two writes are ignored; after reset control reads 0 and cpu_data_out=0.

Source files
------------

// File: rtl/aes_coprocessor_mmio_if.sv
// CPU word bus into the AES coprocessor window.
//   cpu_addr_in          byte address from the CPU; bits[1:0] are ignored
//   cpu_data_in          write data
//   cpu_write_enable_in  per-byte write strobes; all zero means read
//   cpu_data_out         registered read data, one cycle after the address
interface aes_coprocessor_mmio_if;
  logic [31:0] cpu_addr_in;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_write_enable_in;
  logic [31:0] cpu_data_out;

  modport master (
    output cpu_addr_in,
    output cpu_data_in,
    output cpu_write_enable_in,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_addr_in,
    input  cpu_data_in,
    input  cpu_write_enable_in,
    output cpu_data_out
  );
endinterface

// File: rtl/aes_coprocessor_mmio.sv
// Memory-mapped AES-128 coprocessor at 0x0004_xxxx.
// The CPU fills the input buffer and key, writes ENC or DEC to control, polls
// DONE, then reads the output buffer. A sequencer streams 128-bit blocks
// through aes128_core until a terminator word or the end of the buffer.
//   clk_in   system clock
//   rst_in   asynchronous active-high reset
//   cpu      CPU word bus (slave side), see aes_coprocessor_mmio_if

// Iterative AES-128 core: 10 cycles of key expansion, then one round per cycle.
//   start_in/decrypt_in/key_in/block_in  sampled when idle and start_in is high
//   block_out/done_out                   result and its 1-cycle valid pulse
module aes128_core (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic         decrypt_in,
  input  logic [127:0] key_in,
  input  logic [127:0] block_in,
  output logic [127:0] block_out,
  output logic         done_out
);
  typedef enum logic [1:0] {C_IDLE, C_KEXP, C_RND} cstate_e;

  cstate_e      cst_q, cst_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         dec_q, dec_d;
  logic         done_q, done_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [127:0] nk_c, t_c;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  // Byte i of the state is s[127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
        o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
      end
    return o;
  endfunction

  // Output row r of a column is sum_k m[k] * a[(r+k)%4].
  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin
      m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
    end else begin
      m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[k], s[127-8*(4*c+(r+k)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Next-state: load, expand all round keys, then run ten rounds.
  always_comb begin
    cst_d  = cst_q;
    rnd_d  = rnd_q;
    rcon_d = rcon_q;
    dec_d  = dec_q;
    done_d = 1'b0;
    blk_d  = blk_q;
    st_d   = st_q;
    out_d  = out_q;
    nk_c   = '0;
    t_c    = '0;
    for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];
    case (cst_q)
      C_IDLE: begin
        if (start_in) begin
          rk_d[0] = key_in;
          blk_d   = block_in;
          dec_d   = decrypt_in;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          cst_d   = C_KEXP;
        end
      end
      C_KEXP: begin
        nk_c        = key_step(rk_q[rnd_q - 4'd1], rcon_q);
        rk_d[rnd_q] = nk_c;
        rcon_d      = xt(rcon_q);
        rnd_d       = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          // Initial AddRoundKey: decryption starts from the last round key.
          st_d  = blk_q ^ (dec_q ? nk_c : rk_q[0]);
          rnd_d = 4'd1;
          cst_d = C_RND;
        end
      end
      C_RND: begin
        if (!dec_q) begin
          t_c = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
          if (rnd_q != 4'd10) t_c = mix_cols(t_c, 1'b0);
          st_d = t_c ^ rk_q[rnd_q];
        end else begin
          t_c = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_q[4'd10 - rnd_q];
          if (rnd_q != 4'd10) t_c = mix_cols(t_c, 1'b1);
          st_d = t_c;
        end
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          out_d  = st_d;
          done_d = 1'b1;
          cst_d  = C_IDLE;
        end
      end
      default: cst_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cst_q  <= C_IDLE;
      rnd_q  <= 4'd0;
      rcon_q <= 8'h01;
      dec_q  <= 1'b0;
      done_q <= 1'b0;
      blk_q  <= '0;
      st_q   <= '0;
      out_q  <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      cst_q  <= cst_d;
      rnd_q  <= rnd_d;
      rcon_q <= rcon_d;
      dec_q  <= dec_d;
      done_q <= done_d;
      blk_q  <= blk_d;
      st_q   <= st_d;
      out_q  <= out_d;
      for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign block_out = out_q;
  assign done_out  = done_q;
endmodule

module aes_coprocessor_mmio #(
  parameter int unsigned BUF_WORDS  = 256,
  parameter logic [31:0] TERMINATOR = 32'hDEADBEEF
) (
  input logic                    clk_in,
  input logic                    rst_in,
  aes_coprocessor_mmio_if.slave  cpu
);
  localparam int unsigned AW         = $clog2(BUF_WORDS);
  localparam int unsigned OW         = AW + 1;
  localparam int unsigned BW         = AW - 1;
  localparam int unsigned MAX_BLOCKS = BUF_WORDS / 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_RUN, S_STORE, S_FINISH, S_DONE
  } state_e;

  logic [31:0] in_mem  [BUF_WORDS];
  logic [31:0] out_mem [BUF_WORDS];
  logic [31:0] key_q   [4];

  state_e         state_q, state_d;
  logic [BW-1:0]  blk_idx_q, blk_idx_d;
  logic           term_q, term_d;
  logic           dec_q, dec_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           core_start_q, core_start_d;
  logic [127:0]   blk_q, blk_d;
  logic [127:0]   res_q, res_d;
  logic [31:0]    rdata_q;

  logic [15:0]    off_c;
  logic           in_win_c, sel_in_c, sel_out_c, sel_key_c, sel_ctl_c;
  logic [AW-1:0]  widx_c;
  logic [1:0]     kidx_c;
  logic           wr_c, start_acc_c;
  logic [31:0]    rdata_c;
  logic [AW-1:0]  fetch_base_c;
  logic [OW-1:0]  oidx_c [4];
  logic [127:0]   core_out;
  logic           core_done;
  logic [1:0]     unused_addr_c;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Address decode: four 1 KB regions within the 64 KB window.
  always_comb begin
    off_c     = cpu.cpu_addr_in[15:0];
    in_win_c  = (cpu.cpu_addr_in[31:16] == 16'h0004);
    sel_in_c  = in_win_c && (off_c[15:10] == 6'd0);
    sel_out_c = in_win_c && (off_c[15:10] == 6'd1);
    sel_key_c = in_win_c && (off_c[15:4] == 12'h080);
    sel_ctl_c = in_win_c && (off_c[15:2] == 14'h0400);
    widx_c    = off_c[AW+1:2];
    kidx_c    = off_c[3:2];
    wr_c      = |cpu.cpu_write_enable_in;
  end

  assign unused_addr_c = cpu.cpu_addr_in[1:0];

  // A start needs byte 0 strobed, exactly one of ENC/DEC, and an idle engine.
  assign start_acc_c = wr_c && sel_ctl_c && cpu.cpu_write_enable_in[0] &&
                       (cpu.cpu_data_in[0] ^ cpu.cpu_data_in[1]) && !busy_q;

  always_comb begin
    rdata_c = '0;
    if (sel_in_c)       rdata_c = in_mem[widx_c];
    else if (sel_out_c) rdata_c = out_mem[widx_c];
    else if (sel_key_c) rdata_c = key_q[kidx_c];
    else if (sel_ctl_c) rdata_c = {28'd0, busy_q, done_q, 2'b00};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rdata_q <= '0;
    else        rdata_q <= rdata_c;
  end

  assign cpu.cpu_data_out = rdata_q;

  // Input buffer: CPU-written only while idle; not reset.
  always_ff @(posedge clk_in) begin
    if (wr_c && sel_in_c && !busy_q)
      in_mem[widx_c] <= merge(in_mem[widx_c], cpu.cpu_data_in, cpu.cpu_write_enable_in);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) key_q[i] <= '0;
    end else if (wr_c && sel_key_c && !busy_q) begin
      key_q[kidx_c] <= merge(key_q[kidx_c], cpu.cpu_data_in, cpu.cpu_write_enable_in);
    end
  end

  assign fetch_base_c = AW'({blk_idx_q, 2'b00});

  // Output slot 1+4b+k; the last word of block 63 falls off the buffer end.
  always_comb begin
    for (int k = 0; k < 4; k++) oidx_c[k] = {blk_idx_q, 2'b00} + OW'(k + 1);
  end

  // Output buffer: written only by the sequencer; not reset.
  always_ff @(posedge clk_in) begin
    if (state_q == S_STORE) begin
      for (int k = 0; k < 4; k++)
        if (!oidx_c[k][AW]) out_mem[oidx_c[k][AW-1:0]] <= res_q[127-32*k -: 32];
    end
    if (state_q == S_FINISH) begin
      out_mem[0] <= 32'(blk_idx_q);
      if (term_q) out_mem[oidx_c[0][AW-1:0]] <= TERMINATOR;
    end
  end

  // Sequencer next-state.
  always_comb begin
    state_d      = state_q;
    blk_idx_d    = blk_idx_q;
    term_d       = term_q;
    dec_d        = dec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    blk_d        = blk_q;
    res_d        = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc_c) begin
          busy_d    = 1'b1;
          done_d    = 1'b0;
          dec_d     = cpu.cpu_data_in[1];
          blk_idx_d = '0;
          term_d    = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        blk_d   = {in_mem[fetch_base_c], in_mem[{fetch_base_c[AW-1:2], 2'd1}],
                   in_mem[{fetch_base_c[AW-1:2], 2'd2}], in_mem[{fetch_base_c[AW-1:2], 2'd3}]};
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Buffer-end test first: at b == MAX_BLOCKS the fetch index has wrapped.
        if (blk_idx_q == BW'(MAX_BLOCKS)) begin
          state_d = S_FINISH;
        end else if (blk_q[127:96] == TERMINATOR) begin
          term_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          core_start_d = 1'b1;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done) begin
          res_d   = core_out;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        blk_idx_d = blk_idx_q + BW'(1);
        state_d   = S_FETCH;
      end
      S_FINISH: state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      blk_idx_q    <= '0;
      term_q       <= 1'b0;
      dec_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      blk_q        <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      blk_idx_q    <= blk_idx_d;
      term_q       <= term_d;
      dec_q        <= dec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      blk_q        <= blk_d;
      res_q        <= res_d;
    end
  end

  aes128_core u_core (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (core_start_q),
    .decrypt_in (dec_q),
    .key_in     ({key_q[0], key_q[1], key_q[2], key_q[3]}),
    .block_in   (blk_q),
    .block_out  (core_out),
    .done_out   (core_done)
  );
endmodule

// File: tb/tb_aes_coprocessor_mmio.sv
// Directed bench for aes_coprocessor_mmio: register map, strobes, FIPS-197
// vectors, round trips, buffer-end handling, control filtering and reset.
module tb_aes_coprocessor_mmio;
  localparam logic [31:0] IN  = 32'h0004_0000;
  localparam logic [31:0] OUT = 32'h0004_0400;
  localparam logic [31:0] KEY = 32'h0004_0800;
  localparam logic [31:0] CTL = 32'h0004_1000;
  localparam logic [31:0] TRM = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_coprocessor_mmio_if bus ();

  aes_coprocessor_mmio dut (
    .clk_in (clk),
    .rst_in (rst),
    .cpu    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] pt  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] ct  [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [31:0] kk  [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] pt2 [8] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                           32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
  logic [31:0] zct [4] = '{32'h66e94bd4, 32'hef8a2c3b, 32'h884cfa59, 32'hca342b2e};
  logic [31:0] cbuf [8];
  logic [31:0] v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we = 4'hF);
    @(negedge clk);
    bus.cpu_addr_in         = a;
    bus.cpu_data_in         = d;
    bus.cpu_write_enable_in = we;
    @(negedge clk);
    bus.cpu_write_enable_in = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cpu_addr_in         = a;
    bus.cpu_write_enable_in = 4'h0;
    @(negedge clk);
    d = bus.cpu_data_out;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    s = '0;
    n = 0;
    do begin
      rd(CTL, s);
      n++;
    end while (!s[2] && n < 3000);
    chk(tag, s, 32'h4);
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_addr_in         = '0;
    bus.cpu_data_in         = '0;
    bus.cpu_write_enable_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", bus.cpu_data_out, 32'h0);
    rst = 1'b0;
    rd(CTL, v);             chk("rst_ctl", v, 32'h0);
    rd(KEY, v);             chk("rst_key0", v, 32'h0);

    // Word writes, low address bits ignored.
    wr(IN + 32'h000, 32'h6b2ee973);
    wr(IN + 32'h01D, 32'h579cac51);
    rd(IN + 32'h000, v);    chk("t1_w0", v, 32'h6b2ee973);
    rd(IN + 32'h01C, v);    chk("t1_w7", v, 32'h579cac51);

    // Byte strobes.
    wr(IN + 32'h004, 32'h11223344);
    wr(IN + 32'h004, 32'h000000FF, 4'b0001);
    rd(IN + 32'h004, v);    chk("t2_strobe", v, 32'h112233FF);

    // Outside the window and unmapped holes.
    wr(32'h0005_0000, 32'h12345678);
    rd(IN, v);              chk("alias_w0", v, 32'h6b2ee973);
    rd(32'h0005_0000, v);   chk("outside", v, 32'h0);
    rd(KEY + 32'h010, v);   chk("hole", v, 32'h0);

    // FIPS-197 C.1 encryption.
    for (int i = 0; i < 4; i++) wr(KEY + 32'(4 * i), kk[i]);
    for (int i = 0; i < 4; i++) wr(IN + 32'(4 * i), pt[i]);
    wr(IN + 32'h010, TRM);
    wr(CTL, 32'h1);
    rd(CTL, v);             chk("t3_busy", v, 32'h8);
    wr(IN, 32'hFFFFFFFF);
    wr(KEY, 32'h0);
    wait_done("t3_done");
    rd(IN, v);              chk("busy_in_wr", v, pt[0]);
    rd(KEY, v);             chk("busy_key_wr", v, kk[0]);
    rd(OUT, v);             chk("t3_count", v, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(OUT + 32'(4 + 4 * i), v);
      chk($sformatf("t3_ct%0d", i), v, ct[i]);
    end
    rd(OUT + 32'h014, v);   chk("t3_term", v, TRM);
    wr(OUT + 32'h004, 32'h0);
    rd(OUT + 32'h004, v);   chk("out_ro", v, ct[0]);

    // FIPS-197 C.1 decryption.
    for (int i = 0; i < 4; i++) wr(IN + 32'(4 * i), ct[i]);
    wr(CTL, 32'h2);
    wait_done("t4_done");
    for (int i = 0; i < 4; i++) begin
      rd(OUT + 32'(4 + 4 * i), v);
      chk($sformatf("t4_pt%0d", i), v, pt[i]);
    end

    // Two-block round trip.
    for (int i = 0; i < 8; i++) wr(IN + 32'(4 * i), pt2[i]);
    wr(IN + 32'h020, TRM);
    wr(CTL, 32'h1);
    wait_done("t5_enc_done");
    rd(OUT, v);             chk("t5_count", v, 32'd2);
    rd(OUT + 32'h024, v);   chk("t5_term", v, TRM);
    for (int i = 0; i < 8; i++) rd(OUT + 32'(4 + 4 * i), cbuf[i]);
    chk("t5_ct0", cbuf[0], ct[0]);
    chk("t5_ct3", cbuf[3], ct[3]);
    for (int i = 0; i < 8; i++) wr(IN + 32'(4 * i), cbuf[i]);
    wr(CTL, 32'h2);
    wait_done("t5_dec_done");
    rd(OUT, v);             chk("t5_dcount", v, 32'd2);
    for (int i = 0; i < 8; i++) begin
      rd(OUT + 32'(4 + 4 * i), v);
      chk($sformatf("t5_rt%0d", i), v, pt2[i]);
    end

    // Full buffer, no terminator: zero key, zero data.
    for (int i = 0; i < 4; i++) wr(KEY + 32'(4 * i), 32'h0);
    for (int i = 0; i < 256; i++) wr(IN + 32'(4 * i), 32'h0);
    wr(CTL, 32'h1);
    wait_done("full_done");
    rd(OUT, v);             chk("full_count", v, 32'd64);
    rd(OUT + 32'h004, v);   chk("full_b0w0", v, zct[0]);
    rd(OUT + 32'h010, v);   chk("full_b0w3", v, zct[3]);
    rd(OUT + 32'h3F4, v);   chk("full_b63w0", v, zct[0]);
    rd(OUT + 32'h3FC, v);   chk("full_b63w2", v, zct[2]);

    // Control filtering and reset mid-run.
    wr(CTL, 32'h3);
    rd(CTL, v);             chk("ctl_both", v, 32'h4);
    wr(CTL, 32'h1, 4'b0010);
    rd(CTL, v);             chk("ctl_nostrb", v, 32'h4);
    wr(KEY, 32'hA5A5A5A5);
    wr(CTL, 32'h1);
    rd(CTL, v);             chk("t6_busy", v, 32'h8);
    wr(CTL, 32'h1);
    rd(CTL, v);             chk("t6_rewrite", v, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_dout", bus.cpu_data_out, 32'h0);
    rst = 1'b0;
    rd(CTL, v);             chk("t6_rst_ctl", v, 32'h0);
    rd(KEY, v);             chk("t6_rst_key", v, 32'h0);
    repeat (200) @(negedge clk);
    rd(CTL, v);             chk("t6_no_done", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
